// File: rtl/wb_load_unit_pkg.sv
// Shared definitions for the writeback/load unit: FSM states, load width codes,
// exception cause codes and the load legality checks used at accept time.
package wb_load_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MEM   = 2'd1,
    S_WRITE = 2'd2
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (f3 == F3_LH || f3 == F3_LHU) bad = lo[0];
    else if (f3 == F3_LW)            bad = (lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/wb_load_unit_load_align.sv
// Selects the addressed byte/halfword/word from a memory read word and
// sign- or zero-extends it to the datapath width.
module wb_load_unit_load_align
  import wb_load_unit_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] rdata,
  input  logic [1:0]   addr,
  input  logic [2:0]   funct3,
  output logic [N-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    byte_sel = rdata[{addr, 3'b000} +: 8];
    half_sel = rdata[{addr[1], 4'b0000} +: 16];
    data     = rdata;
    case (funct3)
      F3_LB:   data = {{(N-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data = {{(N-8){1'b0}}, byte_sel};
      F3_LH:   data = {{(N-16){half_sel[15]}}, half_sel};
      F3_LHU:  data = {{(N-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_load_unit.sv
// Writeback stage: retires ALU results directly and runs loads through a
// request/ack handshake with data memory before driving the register file write port.
module wb_load_unit
  import wb_load_unit_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ex_valid,
  output logic         ex_ready,
  input  logic         ex_is_load,
  input  logic [2:0]   ex_funct3,
  input  logic [4:0]   ex_rd,
  input  logic [N-1:0] ex_result,
  output logic         mem_req,
  output logic [N-1:0] mem_addr,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic         RegWrite,
  output logic [4:0]   WriteReg,
  output logic [N-1:0] WriteData,
  output logic         exc,
  output logic [1:0]   exc_cause
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         rd_q, rd_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         lo_q, lo_d;
  logic               mem_req_d, reg_write_d, exc_d;
  logic [N-1:0]       mem_addr_d, write_data_d, aligned;
  logic [4:0]         write_reg_d;
  logic [1:0]         cause_d;

  wb_load_unit_load_align #(.N(N)) u_load_align (
    .rdata  (mem_rdata),
    .addr   (lo_q),
    .funct3 (f3_q),
    .data   (aligned)
  );

  assign ex_ready = (state_q == S_IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_d         = rd_q;
    f3_d         = f3_q;
    lo_d         = lo_q;
    mem_req_d    = mem_req;
    mem_addr_d   = mem_addr;
    reg_write_d  = 1'b0;
    write_reg_d  = WriteReg;
    write_data_d = WriteData;
    exc_d        = 1'b0;
    cause_d      = CAUSE_NONE;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          rd_d = ex_rd;
          f3_d = ex_funct3;
          lo_d = ex_result[1:0];
          if (!ex_is_load) begin
            state_d      = S_WRITE;
            reg_write_d  = (ex_rd != 5'd0);
            write_reg_d  = ex_rd;
            write_data_d = ex_result;
          end else if (f3_illegal(ex_funct3)) begin
            exc_d   = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else if (addr_misaligned(ex_funct3, ex_result[1:0])) begin
            exc_d   = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d    = S_MEM;
            cnt_d      = '0;
            mem_req_d  = 1'b1;
            mem_addr_d = {ex_result[N-1:2], 2'b00};
          end
        end
      end
      S_MEM: begin
        // Ack is tested first so it wins over a timeout firing in the same cycle.
        if (mem_ack) begin
          state_d      = S_WRITE;
          mem_req_d    = 1'b0;
          reg_write_d  = (rd_q != 5'd0);
          write_reg_d  = rd_q;
          write_data_d = aligned;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          exc_d     = 1'b1;
          cause_d   = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      f3_q      <= '0;
      lo_q      <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      exc       <= 1'b0;
      exc_cause <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      f3_q      <= f3_d;
      lo_q      <= lo_d;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
      RegWrite  <= reg_write_d;
      WriteReg  <= write_reg_d;
      WriteData <= write_data_d;
      exc       <= exc_d;
      exc_cause <= cause_d;
    end
  end

endmodule

// File: tb/tb_wb_load_unit.sv
// Self-checking bench for wb_load_unit: directed stimulus pushes expected
// register writes / exceptions into a queue, a negedge monitor pops and compares.
module tb_wb_load_unit;

  localparam int N       = 32;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         ex_valid, ex_ready, ex_is_load;
  logic [2:0]   ex_funct3;
  logic [4:0]   ex_rd;
  logic [N-1:0] ex_result;
  logic         mem_req, mem_ack;
  logic [N-1:0] mem_addr, mem_rdata;
  logic         RegWrite;
  logic [4:0]   WriteReg;
  logic [N-1:0] WriteData;
  logic         exc;
  logic [1:0]   exc_cause;

  wb_load_unit #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_is_load(ex_is_load),
    .ex_funct3 (ex_funct3),
    .ex_rd     (ex_rd),
    .ex_result (ex_result),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .exc       (exc),
    .exc_cause (exc_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_exc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  cause;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Scoreboard monitor: every write or exception must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (RegWrite === 1'b1 && exc === 1'b1) check("exc_with_write", 32'd1, 32'd0);
      if (exc === 1'b0 && exc_cause !== 2'b00) check("cause_idle", {30'd0, exc_cause}, 32'd0);
      if (RegWrite === 1'b1 || exc === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_event: RegWrite=%0b exc=%0b WriteReg=%0d WriteData=0x%0h cause=%0b",
                   RegWrite, exc, WriteReg, WriteData, exc_cause);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("event_kind", {31'd0, exc}, {31'd0, e.is_exc});
          if (e.is_exc) begin
            check("exc_cause", {30'd0, exc_cause}, {30'd0, e.cause});
          end else begin
            check("write_reg", {27'd0, WriteReg}, {27'd0, e.rd});
            check("write_data", WriteData, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic is_load, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] res);
    int budget;
    budget = 0;
    while (ex_ready !== 1'b1 && budget < 50) begin
      tick();
      budget++;
    end
    check("accept_ready", {31'd0, ex_ready}, 32'd1);
    ex_valid   = 1'b1;
    ex_is_load = is_load;
    ex_funct3  = f3;
    ex_rd      = rd;
    ex_result  = res;
    tick();
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
    ex_funct3  = 3'b000;
    ex_rd      = 5'd0;
    ex_result  = '0;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] res);
    if (rd != 5'd0) q.push_back('{is_exc: 1'b0, rd: rd, data: res, cause: 2'b00});
    accept(1'b0, 3'b000, rd, res);
    check("alu_latency", {31'd0, RegWrite}, {31'd0, (rd != 5'd0)});
    check("alu_ready_low", {31'd0, ex_ready}, 32'd0);
    tick();
    check("alu_ready_back", {31'd0, ex_ready}, 32'd1);
    check("alu_write_one_cycle", {31'd0, RegWrite}, 32'd0);
  endtask

  task automatic load_op(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] addr, input int k, input logic [31:0] rdata,
                         input logic [31:0] expv);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    if (rd != 5'd0) q.push_back('{is_exc: 1'b0, rd: rd, data: expv, cause: 2'b00});
    accept(1'b1, f3, rd, addr);
    for (int i = 0; i <= k; i++) begin
      check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
      check({tag, "_mem_addr"}, mem_addr, waddr);
      if (i == k) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end
      tick();
    end
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check({tag, "_req_drop"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_write_latency"}, {31'd0, RegWrite}, {31'd0, (rd != 5'd0)});
    check({tag, "_ready_low"}, {31'd0, ex_ready}, 32'd0);
    tick();
    check({tag, "_ready_back"}, {31'd0, ex_ready}, 32'd1);
  endtask

  task automatic exc_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [1:0] cause);
    q.push_back('{is_exc: 1'b1, rd: 5'd0, data: 32'd0, cause: cause});
    accept(1'b1, f3, 5'd12, addr);
    check({tag, "_exc"}, {31'd0, exc}, 32'd1);
    check({tag, "_no_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_stay_idle"}, {31'd0, ex_ready}, 32'd1);
    tick();
    check({tag, "_exc_pulse"}, {31'd0, exc}, 32'd0);
    check({tag, "_no_req_after"}, {31'd0, mem_req}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ex_ready"}, {31'd0, ex_ready}, 32'd1);
    check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_RegWrite"}, {31'd0, RegWrite}, 32'd0);
    check({tag, "_WriteReg"}, {27'd0, WriteReg}, 32'd0);
    check({tag, "_WriteData"}, WriteData, 32'd0);
    check({tag, "_exc"}, {31'd0, exc}, 32'd0);
    check({tag, "_exc_cause"}, {30'd0, exc_cause}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

  initial begin
    int cnt;
    rst        = 1'b0;
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
    ex_funct3  = 3'b000;
    ex_rd      = 5'd0;
    ex_result  = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // ALU writes, including back-to-back and rd=0
    alu_op(5'd5, 32'h1234_5678);
    alu_op(5'd31, 32'hFFFF_FFFF);
    alu_op(5'd0, 32'hA5A5_A5A5);

    // Loads: extraction, sign/zero extension, ack latency
    load_op("lb_sign",  F3_LB(),  5'd3,  32'h103, 3, 32'h80FF_00AA, 32'hFFFF_FF80);
    load_op("lbu_zero", F3_LBU(), 5'd3,  32'h103, 3, 32'h80FF_00AA, 32'h0000_0080);
    load_op("lh_hi",    F3_LH(),  5'd6,  32'h102, 0, 32'h80FF_00AA, 32'hFFFF_80FF);
    load_op("lhu_lo",   F3_LHU(), 5'd6,  32'h100, 1, 32'h80FF_00AA, 32'h0000_00AA);
    load_op("lb_lane2", F3_LB(),  5'd8,  32'h102, 2, 32'h80FF_00AA, 32'hFFFF_FFFF);
    load_op("lbu_lane1",F3_LBU(), 5'd8,  32'h101, 0, 32'h80FF_00AA, 32'h0000_0000);
    load_op("lh_pos",   F3_LH(),  5'd10, 32'h102, 0, 32'h7FFF_8000, 32'h0000_7FFF);
    load_op("lh_neg",   F3_LH(),  5'd10, 32'h100, 0, 32'h7FFF_8000, 32'hFFFF_8000);
    load_op("lw_ackwins", F3_LW(), 5'd9, 32'h300, TIMEOUT - 1, 32'hCAFE_F00D, 32'hCAFE_F00D);
    load_op("lw_rd0",   F3_LW(),  5'd0,  32'h000, 1, 32'hDEAD_BEEF, 32'h0);

    // Illegal width and misalignment, illegal takes priority
    exc_op("lw_mis",   F3_LW(),  32'h102, 2'b01);
    exc_op("f3_011",   3'b011,   32'h100, 2'b10);
    exc_op("f3_111",   3'b111,   32'h101, 2'b10);
    exc_op("f3_110",   3'b110,   32'h000, 2'b10);
    exc_op("lh_mis",   F3_LH(),  32'h103, 2'b01);
    exc_op("lhu_mis",  F3_LHU(), 32'h101, 2'b01);

    // Timeout: no ack, then a late ack in IDLE must be ignored
    q.push_back('{is_exc: 1'b1, rd: 5'd0, data: 32'd0, cause: 2'b11});
    accept(1'b1, F3_LH(), 5'd7, 32'h200);
    cnt = 0;
    while (mem_req === 1'b1 && cnt < TIMEOUT + 4) begin
      cnt++;
      tick();
    end
    check("timeout_req_cycles", cnt, TIMEOUT);
    check("timeout_exc", {31'd0, exc}, 32'd1);
    check("timeout_no_write", {31'd0, RegWrite}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1122_3344;
    tick();
    mem_ack   = 1'b0;
    check("late_ack_no_write", {31'd0, RegWrite}, 32'd0);
    check("late_ack_idle", {31'd0, ex_ready}, 32'd1);
    tick();
    check("late_ack_no_write2", {31'd0, RegWrite}, 32'd0);

    // Reset while a request is in flight
    accept(1'b1, F3_LW(), 5'd4, 32'h400);
    tick();
    check("midmem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    tick();
    check_reset_outputs("midmem_reset");
    rst       = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    tick();
    mem_ack   = 1'b0;
    check("post_reset_no_write", {31'd0, RegWrite}, 32'd0);
    check("post_reset_no_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("post_reset_no_write2", {31'd0, RegWrite}, 32'd0);

    tick();
    tick();
    check("scoreboard_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  function automatic logic [2:0] F3_LB();  return 3'b000; endfunction
  function automatic logic [2:0] F3_LH();  return 3'b001; endfunction
  function automatic logic [2:0] F3_LW();  return 3'b010; endfunction
  function automatic logic [2:0] F3_LBU(); return 3'b100; endfunction
  function automatic logic [2:0] F3_LHU(); return 3'b101; endfunction

endmodule

// File: doc/wb_load_unit.md
Name: wb_load_unit

Overview:
- Writeback stage sitting directly upstream of the 32-entry register file; it drives the file's write port (RegWrite, WriteReg, WriteData).
- Accepts one retiring instruction at a time from execute:
  - ALU results are written back directly.
  - Loads run a handshake with data memory, then are aligned, sign/zero-extended and written back.
- Detects misaligned loads, illegal load widths and memory timeouts, and suppresses the write for each.

Parameters:
N, 32, datapath width (register/data width)
TIMEOUT, 16, max cycles to wait for mem_ack before aborting (>=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low
ex_valid  in  1  execute presents an instruction
ex_ready  out  1  unit can accept (handshake completes when ex_valid & ex_ready)
ex_is_load  in  1  instruction is a load
ex_funct3  in  3  load width/sign code
ex_rd  in  5  destination register
ex_result  in  N  ALU result, or effective address for loads
mem_req  out  1  load request to data memory
mem_addr  out  N  word-aligned address {ex_result[N-1:2],2'b00}
mem_ack  in  1  memory data valid this cycle
mem_rdata  in  N  memory read word
RegWrite  out  1  register file write enable
WriteReg  out  5  register file write index
WriteData  out  N  register file write data
exc  out  1  one-cycle exception pulse
exc_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout; 00 when exc=0

Behaviour:
- Reset (rst=0 at posedge):
  - State -> IDLE.
  - ex_ready=1; mem_req=0, mem_addr=0, RegWrite=0, WriteReg=0, WriteData=0, exc=0, exc_cause=00.
  - Timeout counter cleared.
  - Overrides everything, including an in-flight request.
- States: IDLE, MEM, WRITE.
- IDLE:
  - ex_ready=1.
  - On accept, latch rd, funct3, result and addr[1:0].
  - Non-load -> WRITE.
  - Load: check in order, illegal funct3 (011, 110, 111) first, then misalignment (LH/LHU with addr[0]=1; LW with addr[1:0]!=0).
    - Illegal or misaligned -> exc pulse next cycle with matching cause; no mem access, no write; stay IDLE.
    - Otherwise -> MEM.
- MEM:
  - ex_ready=0; mem_req=1 with mem_addr held stable until the ack cycle.
  - Counter increments each cycle without ack.
  - mem_ack=1 -> capture extracted data, mem_req=0 next cycle, -> WRITE.
  - Counter reaches TIMEOUT-1 without ack -> exc=1, cause 11, mem_req=0, no write, -> IDLE.
  - An ack arriving in the same cycle the timeout fires wins: data is written, no exception.
- WRITE:
  - ex_ready=0.
  - RegWrite=1 for exactly one cycle, WriteReg=rd, WriteData=latched value.
  - rd==0 -> RegWrite stays 0, but the state still passes through WRITE.
  - -> IDLE.
- Latency:
  - ALU instruction: accept at cycle t, RegWrite at t+1, next accept at t+2.
  - Load with ack k cycles after entering MEM (k>=0): write occurs k+2 cycles after accept.
- Load extraction (on mem_rdata):
  - Byte lane = addr[1:0]; halfword = addr[1] ? [31:16] : [15:0].
  - LB/LH sign-extend to N; LBU/LHU zero-extend; LW passes the word.
- Error handling:
  - mem_ack outside MEM is ignored.
  - exc is never asserted together with RegWrite.
  - Outputs are registered; no combinational path from ex_* to RegWrite.

Decomposition:
- Shared package holds:
  - state encodings;
  - funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101);
  - exc_cause codes.
- One combinational sub-module, load_align: inputs rdata, addr[1:0], funct3; output the extended N-bit value. Instantiated once.

Test Plan:
- ALU write: ex_result=0x12345678, rd=5, non-load -> RegWrite=1 one cycle later, WriteReg=5, WriteData=0x12345678; ex_ready low that cycle only.
- LB sign: addr=0x103, ack after 3 cycles with rdata=0x80FF00AA -> WriteData=0xFFFFFF80; LBU same stimulus -> 0x00000080; mem_addr=0x100 throughout MEM.
- Misaligned/illegal:
  - LW at addr=0x102 -> exc=1, cause=01, mem_req never set, no RegWrite.
  - funct3=011 -> cause=10.
- Timeout: LH at 0x200, no ack -> mem_req high for exactly TIMEOUT cycles, then exc with cause=11, no RegWrite; a late ack in IDLE is ignored.
- rd=0 load: LW at 0x0, ack rdata=0xDEADBEEF -> RegWrite stays 0 and the FSM returns to IDLE on schedule.
- Reset mid-MEM: rst=0 while mem_req=1 -> next cycle mem_req=0, ex_ready=1, all outputs at reset values; a subsequent ack causes no write.
